// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz VGA timing constants shared by the raster timing generator.
package vga_pkg;

    localparam int unsigned COORD_W       = 10;

    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_FRAME_W   = 16;

    function automatic int unsigned sum4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        return a + b + c + d;
    endfunction

    localparam int unsigned H_TOTAL = sum4(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned V_TOTAL = sum4(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with enable; wrap is high on the enabled cycle that returns the count to 0.
module wrap_counter #(
    parameter int unsigned Width   = 10,
    parameter int unsigned Modulus = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             wrap
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);

    logic [Width-1:0] r_count;

    assign wrap  = en && (r_count == Last);
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (wrap) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: chained line/frame counters with all outputs registered from the
// next-state counter values so every output describes the same pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
    input  logic               vga_clk,
    input  logic               reset,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned HTotal = sum4(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned VTotal = sum4(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] HActive    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HSyncStart = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] HSyncEnd   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VActive    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VSyncStart = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] VSyncEnd   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    // Held low for the first edge after reset so the counters present (0,0) on that cycle.
    logic               r_run;
    logic [COORD_W-1:0] w_hc;
    logic [COORD_W-1:0] w_vc;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [COORD_W-1:0] w_hc_next;
    logic [COORD_W-1:0] w_vc_next;

    logic               r_hs;
    logic               r_vs;
    logic               r_blank;
    logic [COORD_W-1:0] r_draw_x;
    logic [COORD_W-1:0] r_draw_y;
    logic               r_line_start;
    logic               r_frame_start;
    logic               r_vblank_start;
    logic [FRAME_W-1:0] r_frame_count;

    wrap_counter #(
        .Width   (COORD_W),
        .Modulus (HTotal)
    ) u_h_counter (
        .clk   (vga_clk),
        .reset (reset),
        .en    (r_run),
        .count (w_hc),
        .wrap  (w_h_wrap)
    );

    wrap_counter #(
        .Width   (COORD_W),
        .Modulus (VTotal)
    ) u_v_counter (
        .clk   (vga_clk),
        .reset (reset),
        .en    (w_h_wrap),
        .count (w_vc),
        .wrap  (w_v_wrap)
    );

    always_comb begin
        w_hc_next = w_hc;
        w_vc_next = w_vc;
        if (w_h_wrap) begin
            w_hc_next = '0;
        end else if (r_run) begin
            w_hc_next = w_hc + 1'b1;
        end
        if (w_v_wrap) begin
            w_vc_next = '0;
        end else if (w_h_wrap) begin
            w_vc_next = w_vc + 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_run          <= 1'b0;
            r_hs           <= 1'b1;
            r_vs           <= 1'b1;
            r_blank        <= 1'b0;
            r_draw_x       <= '0;
            r_draw_y       <= '0;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_run          <= 1'b1;
            r_hs           <= !((w_hc_next >= HSyncStart) && (w_hc_next < HSyncEnd));
            r_vs           <= !((w_vc_next >= VSyncStart) && (w_vc_next < VSyncEnd));
            r_blank        <= (w_hc_next < HActive) && (w_vc_next < VActive);
            r_draw_x       <= w_hc_next;
            r_draw_y       <= w_vc_next;
            r_line_start   <= (w_hc_next == '0);
            r_frame_start  <= (w_hc_next == '0) && (w_vc_next == '0);
            r_vblank_start <= (w_hc_next == '0) && (w_vc_next == VActive);
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign hs           = r_hs;
    assign vs           = r_vs;
    assign blank        = r_blank;
    assign DrawX        = r_draw_x;
    assign DrawY        = r_draw_y;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster; expectations derive from elapsed cycles.
module tb_vga_timing_gen;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 6;
    localparam int unsigned VF = 2;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned FW = 4;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic          vga_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          hs;
    logic          vs;
    logic          blank;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
    logic [FW-1:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: cycles elapsed since the first post-reset cycle.
    int t       = 0;
    bit t_valid = 1'b0;
    int exp_addr;
    int blank_cnt;
    int vs_cnt;
    int vbs_cnt;

    vga_timing_gen #(
        .H_ACTIVE (HA),
        .H_FRONT  (HF),
        .H_SYNC   (HS),
        .H_BACK   (HB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .FRAME_W  (FW)
    ) dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .hs           (hs),
        .vs           (vs),
        .blank        (blank),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic rst);
        int hc;
        int vc;
        int pos;
        int fc;
        reset = rst;
        @(posedge vga_clk);
        #1;
        if (rst) begin
            t_valid = 1'b0;
            check_eq("rst_hs", 32'(hs), 1);
            check_eq("rst_vs", 32'(vs), 1);
            check_eq("rst_blank", 32'(blank), 0);
            check_eq("rst_x", 32'(DrawX), 0);
            check_eq("rst_y", 32'(DrawY), 0);
            check_eq("rst_pulses", 32'({line_start, frame_start, vblank_start}), 0);
            check_eq("rst_frame_count", 32'(frame_count), 0);
        end else begin
            t       = t_valid ? t + 1 : 0;
            t_valid = 1'b1;
            pos = t % FT;
            hc  = t % HT;
            vc  = (t / HT) % VT;
            fc  = (t / FT) % (1 << FW);
            check_eq("draw_x", 32'(DrawX), hc);
            check_eq("draw_y", 32'(DrawY), vc);
            check_eq("hs", 32'(hs), (hc >= HA + HF && hc < HA + HF + HS) ? 0 : 1);
            check_eq("vs", 32'(vs), (vc >= VA + VF && vc < VA + VF + VS) ? 0 : 1);
            check_eq("blank", 32'(blank), (hc < HA && vc < VA) ? 1 : 0);
            check_eq("line_start", 32'(line_start), (hc == 0) ? 1 : 0);
            check_eq("frame_start", 32'(frame_start), (pos == 0) ? 1 : 0);
            check_eq("vblank_start", 32'(vblank_start), (hc == 0 && vc == VA) ? 1 : 0);
            check_eq("frame_count", 32'(frame_count), fc);
            if (pos == 0) begin
                exp_addr  = 0;
                blank_cnt = 0;
                vs_cnt    = 0;
                vbs_cnt   = 0;
            end
            // Renderer view: visible pixels must map to consecutive addresses.
            if (blank) begin
                check_eq("render_addr", 32'(DrawX) + 32'(DrawY) * HA, exp_addr);
                exp_addr++;
            end
            blank_cnt += int'(blank);
            vs_cnt    += int'(!vs);
            vbs_cnt   += int'(vblank_start);
            if (pos == FT - 1) begin
                check_eq("frame_blank_count", blank_cnt, HA * VA);
                check_eq("frame_vs_low_count", vs_cnt, VS * HT);
                check_eq("frame_vblank_pulses", vbs_cnt, 1);
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) step(1'b1);
        // Long enough for frame_count to pass its all-ones value and wrap.
        repeat (17 * FT + 5) step(1'b0);
        // Reset in the middle of a visible line.
        while (!(t_valid && (t % FT) == 3 * HT + 5)) step(1'b0);
        repeat (2) step(1'b1);
        repeat (FT + 2) step(1'b0);
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 3 * FT));
            repeat (n) step(1'b0);
            n = int'($urandom_range(1, 4));
            repeat (n) step(1'b1);
        end
        repeat (2 * FT) step(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
